eq_coeff_commit: RTL and testbench

- Sits directly downstream of the SPI coefficient wrapper and upstream of the three-band biquad cascade.
- Latches each newly received 15-coefficient set into a shadow bank and stability-checks each band sequentially.
- On the next sample boundary, atomically commits the passing bands to the active bank that drives the filters, so the cascade never runs a torn or unstable coefficient set.

---
 rtl/eq_coeff_pkg.sv | 35 +++
 rtl/biquad_stability_check.sv | 29 ++
 rtl/eq_coeff_commit.sv | 168 ++++++++++++++++
 tb/tb_eq_coeff_commit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/eq_coeff_pkg.sv
// Shared types and constants for the EQ coefficient commit path.
package eq_coeff_pkg;

    localparam int COEFF_W   = 16;
    localparam int FRAC_BITS = 14;
    localparam int N_BANDS   = 3;

    typedef logic signed [15:0] coeff_t;

    // Q2.14 unity gain
    localparam coeff_t COEFF_ONE = coeff_t'(1 << FRAC_BITS);

    typedef struct packed {
        coeff_t b0;
        coeff_t b1;
        coeff_t b2;
        coeff_t a1;
        coeff_t a2;
    } biquad_coeffs_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        PENDING = 2'd2
    } commit_state_t;

    // Coefficient set that leaves the signal untouched
    function automatic biquad_coeffs_t pass_through_coeffs();
        biquad_coeffs_t c;
        c    = '0;
        c.b0 = COEFF_ONE;
        return c;
    endfunction

endpackage

// File: rtl/biquad_stability_check.sv
// Combinational stability test for one biquad section (denominator only).
// A section is stable when -1 < a2 < 1 and |a1| < 1 + a2, evaluated in
// 18-bit signed arithmetic so that |a1| and 1 + a2 cannot overflow.
module biquad_stability_check
    import eq_coeff_pkg::*;
(
    input  biquad_coeffs_t coeffs,
    output logic           pass
);

    logic signed [17:0] a1_x;
    logic signed [17:0] a2_x;
    logic signed [17:0] a1_mag;
    logic signed [17:0] limit;

    // Numerator taps do not affect stability
    logic unused_numerator;
    assign unused_numerator = ^{coeffs.b0, coeffs.b1, coeffs.b2};

    // Triangle-of-stability test on a1/a2
    always_comb begin
        a1_x   = {{2{coeffs.a1[15]}}, coeffs.a1};
        a2_x   = {{2{coeffs.a2[15]}}, coeffs.a2};
        a1_mag = a1_x[17] ? -a1_x : a1_x;
        limit  = 18'sd16384 + a2_x;
        pass   = (a2_x > -18'sd16384) && (a2_x < 18'sd16384) && (a1_mag < limit);
    end

endmodule

// File: rtl/eq_coeff_commit.sv
// Shadow/active coefficient bank for the three-band biquad cascade.
// New sets are captured into a shadow bank, checked one band per cycle,
// and the passing bands are copied to the active bank on a sample boundary.
module eq_coeff_commit
    import eq_coeff_pkg::*;
#(
    parameter int COEFF_W   = 16,
    parameter int FRAC_BITS = 14,
    parameter int N_BANDS   = 3
)
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      coeff_valid,
    input  logic signed [COEFF_W-1:0] low_b0,
    input  logic signed [COEFF_W-1:0] low_b1,
    input  logic signed [COEFF_W-1:0] low_b2,
    input  logic signed [COEFF_W-1:0] low_a1,
    input  logic signed [COEFF_W-1:0] low_a2,
    input  logic signed [COEFF_W-1:0] mid_b0,
    input  logic signed [COEFF_W-1:0] mid_b1,
    input  logic signed [COEFF_W-1:0] mid_b2,
    input  logic signed [COEFF_W-1:0] mid_a1,
    input  logic signed [COEFF_W-1:0] mid_a2,
    input  logic signed [COEFF_W-1:0] high_b0,
    input  logic signed [COEFF_W-1:0] high_b1,
    input  logic signed [COEFF_W-1:0] high_b2,
    input  logic signed [COEFF_W-1:0] high_a1,
    input  logic signed [COEFF_W-1:0] high_a2,
    input  logic                      sample_tick,
    output logic signed [COEFF_W-1:0] act_low_b0,
    output logic signed [COEFF_W-1:0] act_low_b1,
    output logic signed [COEFF_W-1:0] act_low_b2,
    output logic signed [COEFF_W-1:0] act_low_a1,
    output logic signed [COEFF_W-1:0] act_low_a2,
    output logic signed [COEFF_W-1:0] act_mid_b0,
    output logic signed [COEFF_W-1:0] act_mid_b1,
    output logic signed [COEFF_W-1:0] act_mid_b2,
    output logic signed [COEFF_W-1:0] act_mid_a1,
    output logic signed [COEFF_W-1:0] act_mid_a2,
    output logic signed [COEFF_W-1:0] act_high_b0,
    output logic signed [COEFF_W-1:0] act_high_b1,
    output logic signed [COEFF_W-1:0] act_high_b2,
    output logic signed [COEFF_W-1:0] act_high_a1,
    output logic signed [COEFF_W-1:0] act_high_a2,
    output logic                      coeff_updated,
    output logic [N_BANDS-1:0]        band_reject,
    output logic [7:0]                drop_count,
    output logic                      busy
);

    localparam logic [1:0] LAST_BAND = 2'(N_BANDS - 1);

    // Pass-through section derived from the local fractional width
    function automatic biquad_coeffs_t unity_coeffs();
        biquad_coeffs_t c;
        c    = '0;
        c.b0 = coeff_t'(1 << FRAC_BITS);
        return c;
    endfunction

    commit_state_t  state;
    logic [1:0]     band_idx;
    logic [N_BANDS-1:0] pass;
    biquad_coeffs_t new_set [N_BANDS];
    biquad_coeffs_t shadow  [N_BANDS];
    biquad_coeffs_t active  [N_BANDS];
    biquad_coeffs_t check_in;
    logic           band_pass;

    assign new_set[0] = {low_b0,  low_b1,  low_b2,  low_a1,  low_a2};
    assign new_set[1] = {mid_b0,  mid_b1,  mid_b2,  mid_a1,  mid_a2};
    assign new_set[2] = {high_b0, high_b1, high_b2, high_a1, high_a2};

    // Route the shadow band currently being checked to the single checker
    always_comb begin
        check_in = shadow[0];
        case (band_idx)
            2'd1:    check_in = shadow[1];
            2'd2:    check_in = shadow[2];
            default: check_in = shadow[0];
        endcase
    end

    biquad_stability_check u_check (
        .coeffs (check_in),
        .pass   (band_pass)
    );

    // Capture, sequential band check and atomic commit on the sample boundary.
    // A capture takes priority over every state action, so a new set arriving
    // with a tick in PENDING discards the old set instead of committing it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            band_idx      <= '0;
            pass          <= '0;
            coeff_updated <= 1'b0;
            band_reject   <= '0;
            drop_count    <= '0;
            for (int unsigned b = 0; b < N_BANDS; b++) begin
                shadow[b] <= '0;
                active[b] <= unity_coeffs();
            end
        end else begin
            coeff_updated <= 1'b0;
            if (coeff_valid) begin
                for (int unsigned b = 0; b < N_BANDS; b++) begin
                    shadow[b] <= new_set[b];
                end
                band_idx <= '0;
                pass     <= '0;
                state    <= CHECK;
                if (state != IDLE && drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    CHECK: begin
                        pass[band_idx] <= band_pass;
                        if (band_idx == LAST_BAND) begin
                            state <= PENDING;
                        end else begin
                            band_idx <= band_idx + 2'd1;
                        end
                    end
                    PENDING: begin
                        if (sample_tick) begin
                            for (int unsigned b = 0; b < N_BANDS; b++) begin
                                if (pass[b]) begin
                                    active[b] <= shadow[b];
                                end
                            end
                            band_reject   <= ~pass;
                            coeff_updated <= |pass;
                            state         <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign busy = (state != IDLE);

    assign act_low_b0  = active[0].b0;
    assign act_low_b1  = active[0].b1;
    assign act_low_b2  = active[0].b2;
    assign act_low_a1  = active[0].a1;
    assign act_low_a2  = active[0].a2;
    assign act_mid_b0  = active[1].b0;
    assign act_mid_b1  = active[1].b1;
    assign act_mid_b2  = active[1].b2;
    assign act_mid_a1  = active[1].a1;
    assign act_mid_a2  = active[1].a2;
    assign act_high_b0 = active[2].b0;
    assign act_high_b1 = active[2].b1;
    assign act_high_b2 = active[2].b2;
    assign act_high_a1 = active[2].a1;
    assign act_high_a2 = active[2].a2;

endmodule

// File: tb/tb_eq_coeff_commit.sv
// Scoreboard bench for eq_coeff_commit: each driven cycle pushes the
// expected post-edge outputs, which are popped and compared after the edge.
module tb_eq_coeff_commit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         coeff_valid;
    logic         sample_tick;
    logic [239:0] in_set;

    logic [15:0] act_low_b0, act_low_b1, act_low_b2, act_low_a1, act_low_a2;
    logic [15:0] act_mid_b0, act_mid_b1, act_mid_b2, act_mid_a1, act_mid_a2;
    logic [15:0] act_high_b0, act_high_b1, act_high_b2, act_high_a1, act_high_a2;
    logic        coeff_updated;
    logic [2:0]  band_reject;
    logic [7:0]  drop_count;
    logic        busy;
    logic [239:0] obs_bank;

    eq_coeff_commit #(.COEFF_W(16), .FRAC_BITS(14), .N_BANDS(3)) dut (
        .clk(clk), .reset(reset), .coeff_valid(coeff_valid),
        .low_b0(in_set[15:0]),     .low_b1(in_set[31:16]),   .low_b2(in_set[47:32]),
        .low_a1(in_set[63:48]),    .low_a2(in_set[79:64]),
        .mid_b0(in_set[95:80]),    .mid_b1(in_set[111:96]),  .mid_b2(in_set[127:112]),
        .mid_a1(in_set[143:128]),  .mid_a2(in_set[159:144]),
        .high_b0(in_set[175:160]), .high_b1(in_set[191:176]), .high_b2(in_set[207:192]),
        .high_a1(in_set[223:208]), .high_a2(in_set[239:224]),
        .sample_tick(sample_tick),
        .act_low_b0(act_low_b0),   .act_low_b1(act_low_b1),   .act_low_b2(act_low_b2),
        .act_low_a1(act_low_a1),   .act_low_a2(act_low_a2),
        .act_mid_b0(act_mid_b0),   .act_mid_b1(act_mid_b1),   .act_mid_b2(act_mid_b2),
        .act_mid_a1(act_mid_a1),   .act_mid_a2(act_mid_a2),
        .act_high_b0(act_high_b0), .act_high_b1(act_high_b1), .act_high_b2(act_high_b2),
        .act_high_a1(act_high_a1), .act_high_a2(act_high_a2),
        .coeff_updated(coeff_updated), .band_reject(band_reject),
        .drop_count(drop_count), .busy(busy)
    );

    assign obs_bank = {act_high_a2, act_high_a1, act_high_b2, act_high_b1, act_high_b0,
                       act_mid_a2,  act_mid_a1,  act_mid_b2,  act_mid_b1,  act_mid_b0,
                       act_low_a2,  act_low_a1,  act_low_b2,  act_low_b1,  act_low_b0};

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [239:0] bank;
        logic [2:0]   rej;
        logic         upd;
        logic [7:0]   drop;
        logic         busy;
    } exp_t;
    exp_t sb[$];

    // Reference model state
    logic [239:0] m_bank;
    logic [239:0] m_pend;
    logic [2:0]   m_rej;
    logic [7:0]   m_drop;
    bit           m_pv;
    int           m_load_edge;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [79:0] mkband(input int b0, input int b1, input int b2,
                                           input int a1, input int a2);
        logic [15:0] f0, f1, f2, f3, f4;
        f0 = 16'(b0); f1 = 16'(b1); f2 = 16'(b2); f3 = 16'(a1); f4 = 16'(a2);
        return {f4, f3, f2, f1, f0};
    endfunction

    function automatic logic [239:0] pass_bank();
        logic [79:0] pb;
        pb = mkband(16384, 0, 0, 0, 0);
        return {pb, pb, pb};
    endfunction

    function automatic bit stable(input logic signed [15:0] a1, input logic signed [15:0] a2);
        int x1, x2, mag;
        x1  = a1;
        x2  = a2;
        mag = (x1 < 0) ? -x1 : x1;
        return (x2 > -16384) && (x2 < 16384) && (mag < 16384 + x2);
    endfunction

    // Drive one cycle, predict the post-edge outputs, then compare them
    task automatic step(input bit r, input bit v, input bit t, input logic [239:0] s);
        exp_t e;
        exp_t got;
        int   edge_no;
        bit   upd;
        bit   p;
        @(negedge clk);
        reset = r; coeff_valid = v; sample_tick = t; in_set = s;
        edge_no = cyc + 1;
        upd = 1'b0;
        if (r) begin
            m_bank = pass_bank(); m_rej = '0; m_drop = '0; m_pv = 1'b0;
        end else if (v) begin
            if (m_pv && m_drop != 8'hFF) m_drop = m_drop + 8'd1;
            m_pend = s; m_pv = 1'b1; m_load_edge = edge_no;
        end else if (t && m_pv && edge_no >= m_load_edge + 4) begin
            for (int b = 0; b < 3; b++) begin
                p = stable(m_pend[b*80+48 +: 16], m_pend[b*80+64 +: 16]);
                if (p) m_bank[b*80 +: 80] = m_pend[b*80 +: 80];
                m_rej[b] = !p;
                if (p) upd = 1'b1;
            end
            m_pv = 1'b0;
        end
        e.bank = m_bank; e.rej = m_rej; e.upd = upd; e.drop = m_drop; e.busy = m_pv;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        for (int k = 0; k < 15; k++)
            check_val($sformatf("coef%0d", k), 32'(obs_bank[k*16 +: 16]), 32'(got.bank[k*16 +: 16]));
        check_val("band_reject",   32'(band_reject),   32'(got.rej));
        check_val("coeff_updated", 32'(coeff_updated), 32'(got.upd));
        check_val("drop_count",    32'(drop_count),    32'(got.drop));
        check_val("busy",          32'(busy),          32'(got.busy));
        reset = 1'b0; coeff_valid = 1'b0; sample_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [239:0] s;
        reset = 1'b1; coeff_valid = 1'b0; sample_tick = 1'b0; in_set = '0;
        m_bank = pass_bank(); m_pend = '0; m_rej = '0; m_drop = '0; m_pv = 1'b0; m_load_edge = 0;

        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        idle(10);

        // All bands stable
        s = {mkband(8192, 1000, 500, -12000, 5000),
             mkband(8192, 3000, 700, -12000, 5000),
             mkband(8192, 4000, 900, -12000, 5000)};
        step(1'b0, 1'b1, 1'b0, s); idle(10); step(1'b0, 1'b0, 1'b1, '0); idle(2);

        // Mid a2 at +1.0 is rejected, mid keeps previous values
        s = {mkband(7000, 11, 12, -12000, 5000),
             mkband(7000, 21, 22, -12000, 16384),
             mkband(7000, 31, 32, -12000, 5000)};
        step(1'b0, 1'b1, 1'b0, s); idle(6); step(1'b0, 1'b0, 1'b1, '0); idle(2);

        // Low |a1| too large
        s = {mkband(6000, 1, 2, -100, 100),
             mkband(6000, 3, 4, -100, 100),
             mkband(6000, 5, 6, 30000, 0)};
        step(1'b0, 1'b1, 1'b0, s); idle(6); step(1'b0, 1'b0, 1'b1, '0); idle(2);

        // Second set arrives while PENDING: first is dropped
        s = {mkband(111, 0, 0, 0, 0), mkband(112, 0, 0, 0, 0), mkband(113, 0, 0, 0, 0)};
        step(1'b0, 1'b1, 1'b0, s); idle(6);
        s = {mkband(211, 1, 1, 1000, 2000), mkband(212, 2, 2, -1000, 2000), mkband(213, 3, 3, 0, 0)};
        step(1'b0, 1'b1, 1'b0, s); idle(6); step(1'b0, 1'b0, 1'b1, '0); idle(2);

        // New set and tick in the same PENDING cycle
        s = {mkband(311, 0, 0, 0, 0), mkband(312, 0, 0, 0, 0), mkband(313, 0, 0, 0, 0)};
        step(1'b0, 1'b1, 1'b0, s); idle(6);
        s = {mkband(411, 9, 9, 500, 500), mkband(412, 9, 9, 600, 600), mkband(413, 9, 9, 700, 700)};
        step(1'b0, 1'b1, 1'b1, s); idle(6); step(1'b0, 1'b0, 1'b1, '0); idle(2);

        // Tick during the first CHECK cycle is ignored
        s = {mkband(511, 5, 5, 0, 0), mkband(512, 5, 5, 0, 0), mkband(513, 5, 5, 0, 0)};
        step(1'b0, 1'b1, 1'b0, s); step(1'b0, 1'b0, 1'b1, '0); idle(6);
        step(1'b0, 1'b0, 1'b1, '0); idle(2);

        // Reset while PENDING discards the set
        s = {mkband(611, 6, 6, 0, 0), mkband(612, 6, 6, 0, 0), mkband(613, 6, 6, 0, 0)};
        step(1'b0, 1'b1, 1'b0, s); idle(6); step(1'b1, 1'b0, 1'b0, '0); idle(2);
        step(1'b0, 1'b0, 1'b1, '0); idle(2);

        // Stability boundaries: low/mid just inside, high exactly on the edge
        s = {mkband(711, 0, 0, 1, -16383),
             mkband(712, 0, 0, 0, -16383),
             mkband(713, 0, 0, 32766, 16383)};
        step(1'b0, 1'b1, 1'b0, s); idle(6); step(1'b0, 1'b0, 1'b1, '0); idle(2);

        // Every band fails
        s = {mkband(811, 0, 0, -32768, 0),
             mkband(812, 0, 0, 0, 20000),
             mkband(813, 0, 0, 0, -16384)};
        step(1'b0, 1'b1, 1'b0, s); idle(6); step(1'b0, 1'b0, 1'b1, '0); idle(2);

        // Back-to-back captures saturate the drop counter
        for (int i = 0; i < 260; i++) begin
            s = {mkband(900 + i, 0, 0, 0, 0), mkband(1200 + i, 0, 0, 0, 0), mkband(1500 + i, 0, 0, 0, 0)};
            step(1'b0, 1'b1, 1'b0, s);
        end
        idle(6); step(1'b0, 1'b0, 1'b1, '0); idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
